// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and anything that
// predecodes fetched words (decode may import this as well).
//   OPC_J     : major opcode of the J-type jump
//   INSTR_NOP : word held in IF/ID after reset
//   state_e   : fetch FSM encoding RUN/HOLD/HALT = 0/1/2
package instruction_fetch_unit_pkg;

  localparam logic [5:0]  OPC_J     = 6'b000010;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/instruction_fetch_unit_jump_predecode.sv
// fetch_jump_predecode: combinational J-type detector and target former.
// Ports:
//   i_instr    in  32  fetched instruction word
//   i_pc_plus4 in  32  address of the word + 4 (supplies the region bits)
//   o_is_j     out 1   word is a J-type jump
//   o_j_target out 32  {pc_plus4[31:28], instr[25:0], 2'b00}
module fetch_jump_predecode
  import instruction_fetch_unit_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic        o_is_j,
  output logic [31:0] o_j_target
);

  assign o_is_j     = (i_instr[31:26] == OPC_J);
  // Target stays within the 256 MB region of the delay-free successor.
  assign o_j_target = (i_pc_plus4 & 32'hF000_0000) | {4'b0000, i_instr[25:0], 2'b00};

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, drives the single-cycle instruction
// memory, captures the returned word into the IF/ID register with a
// valid/ready handshake, follows J-type jumps locally and takes redirects
// from execute. Fetching an address beyond the populated memory halts with
// a sticky fault until the next redirect.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_addr       out 32          byte address = pc
//   imem_instr      in  32          word at imem_addr, same cycle
//   redirect_valid  in  1           PC override (highest priority)
//   redirect_target in  32          new PC, low two bits ignored
//   id_valid/id_ready               IF/ID handshake
//   id_instr, id_pc, id_pc_plus4    IF/ID payload
//   fetch_fault     out 1           sticky out-of-range flag
//   fetch_count     out 32          saturating handshake counter
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LP_WORDS = 32'(IMEM_WORDS);

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr, r_id_pc, r_id_pc_plus4;
  logic        r_fault;
  logic [31:0] r_count;

  logic [31:0] w_pc_plus4, w_next_pc, w_j_target, w_redir_pc;
  logic        w_is_j, w_oor, w_hs, w_load, w_capture, w_set_fault;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redir_pc = redirect_target & 32'hFFFF_FFFC;
  // Range check is on the pc about to be fetched, never on id_pc.
  assign w_oor      = ({2'b00, r_pc[31:2]} >= LP_WORDS);
  assign w_hs       = r_id_valid && id_ready;
  assign w_load     = !r_id_valid || id_ready;

  fetch_jump_predecode u_predecode (
    .i_instr    (imem_instr),
    .i_pc_plus4 (w_pc_plus4),
    .o_is_j     (w_is_j),
    .o_j_target (w_j_target)
  );

  assign w_next_pc = w_is_j ? w_j_target : w_pc_plus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // HOLD behaves like RUN with the load condition false; the cycle id_ready
  // returns is a normal fetch, so the restart has no bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_set_fault = 1'b0;
    if (redirect_valid) begin
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        RUN, HOLD: begin
          if (w_oor) begin
            w_state_nxt = HALT;
            w_set_fault = 1'b1;
          end else if (w_load) begin
            w_state_nxt = RUN;
            w_capture   = 1'b1;
          end else begin
            w_state_nxt = HOLD;
          end
        end
        HALT:    w_state_nxt = HALT;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_instr    <= INSTR_NOP;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
      r_fault       <= 1'b0;
      r_count       <= '0;
    end else begin
      // A handshake counts even when a redirect flushes the same cycle.
      if (w_hs && (r_count != 32'hFFFF_FFFF)) r_count <= r_count + 32'd1;
      if (redirect_valid) begin
        r_pc       <= w_redir_pc;
        r_id_valid <= 1'b0;
        r_fault    <= 1'b0;
      end else if (w_capture) begin
        r_pc          <= w_next_pc;
        r_id_valid    <= 1'b1;
        r_id_instr    <= imem_instr;
        r_id_pc       <= r_pc;
        r_id_pc_plus4 <= w_pc_plus4;
      end else begin
        // No capture: a pending word may still drain to decode.
        if (w_hs)        r_id_valid <= 1'b0;
        if (w_set_fault) r_fault    <= 1'b1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign fetch_fault = r_fault;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } item_t;

  item_t       sb[$];
  logic [31:0] mem [64];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt  = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  // Single-cycle memory: 64 populated words, all-ones beyond.
  always_comb
    imem_instr = (imem_addr[31:8] == 24'h0) ? mem[imem_addr[7:2]] : 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted IF/ID word is compared with the pushed item.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1) begin
      chk("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        item_t it;
        it = sb.pop_front();
        chk("sb_id_pc", id_pc, it.pc);
        chk("sb_id_instr", id_instr, it.instr);
        chk("sb_id_pc_plus4", id_pc_plus4, it.pc4);
      end
    end
  end

  // One clock: check state after the edge, then drive the next interval.
  task automatic cyc(input logic [31:0] ea, input logic ev, input logic [31:0] epc,
                     input logic ef, input logic rdy);
    @(posedge clk); #1;
    chk("imem_addr", imem_addr, ea);
    chk("id_valid", {31'b0, id_valid}, {31'b0, ev});
    if (ev) begin
      chk("id_pc", id_pc, epc);
      chk("id_instr", id_instr, mem[epc[7:2]]);
    end
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, ef});
    chk("fetch_count", fetch_count, exp_cnt);
    redirect_valid = 1'b0;
    id_ready       = rdy;
    if (ev && rdy) begin
      sb.push_back('{pc: epc, instr: mem[epc[7:2]], pc4: epc + 32'd4});
      exp_cnt++;
    end
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_valid"}, {31'b0, id_valid}, 32'h0);
    chk({tag, "_instr"}, id_instr, 32'h0);
    chk({tag, "_pc"},    id_pc, 32'h0);
    chk({tag, "_pc4"},   id_pc_plus4, 32'h0);
    chk({tag, "_fault"}, {31'b0, fetch_fault}, 32'h0);
    chk({tag, "_count"}, fetch_count, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
    mem[0]  = 32'h0010_0093;  // addi x1,x0,1
    mem[1]  = 32'h0020_0113;  // addi x2,x0,2
    mem[2]  = 32'h0020_F1B3;  // and  x3,x1,x2
    mem[3]  = 32'h0020_E233;  // or   x4,x1,x2
    mem[17] = 32'h0800_000E;  // J at 0x44 -> 0x38

    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
    #22;
    chk_reset("reset");
    rst_n = 1'b1;

    // Sequential fetch 0..0x40, id_pc one cycle behind imem_addr.
    for (int k = 1; k <= 17; k++)
      cyc(32'(4 * k), 1'b1, 32'(4 * (k - 1)), 1'b0, 1'b1);
    // J word delivered, pc already at its target.
    cyc(32'h38, 1'b1, 32'h44, 1'b0, 1'b1);
    // Stall three cycles, then resume with pc+4.
    cyc(32'h3C, 1'b1, 32'h38, 1'b0, 1'b0);
    cyc(32'h3C, 1'b1, 32'h38, 1'b0, 1'b0);
    cyc(32'h3C, 1'b1, 32'h38, 1'b0, 1'b0);
    cyc(32'h3C, 1'b1, 32'h38, 1'b0, 1'b1);
    cyc(32'h40, 1'b1, 32'h3C, 1'b0, 1'b1);
    // Redirect to unaligned 0x4B while decode is stalled: flush, pc 0x48.
    cyc(32'h44, 1'b1, 32'h40, 1'b0, 1'b0);
    redir(32'h4B);
    cyc(32'h48, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(32'h4C, 1'b1, 32'h48, 1'b0, 1'b1);
    // Redirect coinciding with a handshake: counted, not captured.
    redir(32'hF8);
    cyc(32'hF8, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(32'hFC, 1'b1, 32'hF8, 1'b0, 1'b1);
    // pc 0x100 is out of range: halt, hold pending word, then drain.
    cyc(32'h100, 1'b1, 32'hFC, 1'b0, 1'b0);
    cyc(32'h100, 1'b1, 32'hFC, 1'b1, 1'b0);
    cyc(32'h100, 1'b1, 32'hFC, 1'b1, 1'b1);
    cyc(32'h100, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(32'h100, 1'b0, 32'h0, 1'b1, 1'b1);
    redir(32'h0);
    cyc(32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(32'h4, 1'b1, 32'h0, 1'b0, 1'b1);
    // Asynchronous reset pulse in the middle of a stall.
    cyc(32'h8, 1'b1, 32'h4, 1'b0, 1'b0);
    #2; rst_n = 1'b0;
    #1; chk_reset("async_rst");
    #3; rst_n = 1'b1; exp_cnt = 0; id_ready = 1'b1;
    cyc(32'h4, 1'b1, 32'h0, 1'b0, 1'b1);
    cyc(32'h8, 1'b1, 32'h4, 1'b0, 1'b1);
    cyc(32'hC, 1'b1, 32'h8, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
